// File: rtl/comb_sweep_pkg.sv
// Shared types and default parameters for the combinational-function sweep controller.
package comb_sweep_pkg;

    localparam int unsigned N_IN_DEF          = 4;
    localparam int unsigned SETTLE_CYCLES_DEF = 4;
    localparam int unsigned SETTLE_W          = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/comb_sweep_timer.sv
// Settle counter: counts cycles a vector has been held; expire_c flags the last settle cycle.
module comb_sweep_timer
    import comb_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_c
);

    logic [SETTLE_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + SETTLE_W'(1);
        end
    end

    assign expire_c = (cnt_q == SETTLE_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/comb_sweep_ctrl.sv
// Exhaustive sweep of all input vectors, comparing two combinational implementations.
module comb_sweep_ctrl
    import comb_sweep_pkg::*;
#(
    parameter int unsigned N_IN          = N_IN_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            z1,
    input  logic            z2,
    output logic [N_IN-1:0] vec,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   mismatch_cnt,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
);

    localparam int unsigned CW = N_IN + 1;

    sweep_state_e    state_q;
    logic [N_IN-1:0] vec_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [N_IN-1:0] ff_vec_q;
    logic            ff_valid_q;
    logic            start_c;
    logic            miss_c;
    logic            expire_c;

    assign start_c = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign miss_c  = z1 ^ z2;
    assign cnt_d   = cnt_q + CW'(miss_c);

    comb_sweep_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (start_c || (state_q == ST_SAMPLE)),
        .en_i     (state_q == ST_SETTLE),
        .expire_c (expire_c)
    );

    // Abort takes priority over the sample so an aborted vector is never counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            vec_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            cnt_q      <= '0;
            ff_vec_q   <= '0;
            ff_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q    <= ST_SETTLE;
                        vec_q      <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        cnt_q      <= '0;
                        ff_vec_q   <= '0;
                        ff_valid_q <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else if (expire_c) begin
                        state_q <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                        if (miss_c && !ff_valid_q) begin
                            ff_vec_q   <= vec_q;
                            ff_valid_q <= 1'b1;
                        end
                        if (vec_q == '1) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (cnt_d == '0);
                        end else begin
                            state_q <= ST_SETTLE;
                            vec_q   <= vec_q + N_IN'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign vec              = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign mismatch_cnt     = cnt_q;
    assign first_fail_vec   = ff_vec_q;
    assign first_fail_valid = ff_valid_q;

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Directed-random bench for comb_sweep_ctrl with a fault-injecting reference function pair.
module tb_comb_sweep_ctrl;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [1:0]            start_s;
    logic [1:0]            abort_s;
    logic [1:0]            z1_s;
    logic [1:0]            z2_s;
    logic [1:0]            busy_s;
    logic [1:0]            done_s;
    logic [1:0]            pass_s;
    logic [1:0]            ffv_s;
    logic [1:0][3:0]       vec_s;
    logic [1:0][3:0]       ffvec_s;
    logic [1:0][4:0]       cnt_s;
    logic [1:0][15:0]      mask_s;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic f_gate(input logic [3:0] v);
        logic a, b, c, d;
        a = v[3]; b = v[2]; c = v[1]; d = v[0];
        return (a & b) | (~c & d);
    endfunction

    function automatic logic f_flow(input logic [3:0] v);
        return (v[3:2] == 2'b11) || (!v[1] && v[0]);
    endfunction

    function automatic logic [3:0] first_set(input logic [15:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) if (m[i]) r = 4'(i);
        return r;
    endfunction

    assign z1_s[0] = f_gate(vec_s[0]);
    assign z2_s[0] = f_flow(vec_s[0]) ^ mask_s[0][vec_s[0]];
    assign z1_s[1] = f_gate(vec_s[1]);
    assign z2_s[1] = f_flow(vec_s[1]) ^ mask_s[1][vec_s[1]];

    comb_sweep_ctrl #(.N_IN(4), .SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]),
        .z1(z1_s[0]), .z2(z2_s[0]), .vec(vec_s[0]), .busy(busy_s[0]),
        .done(done_s[0]), .pass(pass_s[0]), .mismatch_cnt(cnt_s[0]),
        .first_fail_vec(ffvec_s[0]), .first_fail_valid(ffv_s[0])
    );

    comb_sweep_ctrl #(.N_IN(4), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]),
        .z1(z1_s[1]), .z2(z2_s[1]), .vec(vec_s[1]), .busy(busy_s[1]),
        .done(done_s[1]), .pass(pass_s[1]), .mismatch_cnt(cnt_s[1]),
        .first_fail_vec(ffvec_s[1]), .first_fail_valid(ffv_s[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input int d, input string tag);
        check(tag, 32'({vec_s[d], busy_s[d], done_s[d], pass_s[d], cnt_s[d], ffvec_s[d], ffv_s[d]}), 32'd0);
    endtask

    // Full sweep: one start edge, then every cycle checked against the ideal vector schedule.
    task automatic run_sweep(input int d, input logic hold_start, input logic with_abort);
        int          p;
        logic [15:0] m;
        p = (d == 0) ? 5 : 2;
        m = mask_s[d];
        start_s[d] = 1'b1;
        abort_s[d] = with_abort;
        tick();
        abort_s[d] = 1'b0;
        if (!hold_start) start_s[d] = 1'b0;
        check("start_clears", 32'({cnt_s[d], ffv_s[d], ffvec_s[d], pass_s[d]}), 32'd0);
        for (int j = 0; j < 16 * p; j++) begin
            check("sweep_sched", 32'({vec_s[d], busy_s[d], done_s[d]}), 32'({4'(j / p), 1'b1, 1'b0}));
            tick();
        end
        check("done_state", 32'({vec_s[d], busy_s[d], done_s[d]}), 32'({4'hf, 1'b0, 1'b1}));
        check("mismatch_cnt", 32'(cnt_s[d]), 32'($countones(m)));
        check("first_fail_valid", 32'(ffv_s[d]), 32'(m != 16'd0));
        check("first_fail_vec", 32'(ffvec_s[d]), 32'(first_set(m)));
        check("pass", 32'(pass_s[d]), 32'(m == 16'd0));
    endtask

    initial begin
        logic [15:0] m;
        start_s = '0;
        abort_s = '0;
        mask_s  = '0;

        #1 rst = 1'b1;
        #2;
        check_all_zero(0, "reset_dut");
        check_all_zero(1, "reset_dut1");
        #9 rst = 1'b0;
        repeat (9) tick();
        check_all_zero(0, "idle_after_reset");

        // Clean implementations, then faults at vectors 5 and 12.
        mask_s[0] = 16'h0000;
        run_sweep(0, 1'b0, 1'b0);
        mask_s[0] = 16'h1020;
        run_sweep(0, 1'b0, 1'b0);
        check("ffvec_is_5", 32'(ffvec_s[0]), 32'd5);

        // Restart from a failing DONE with a fault-free model.
        mask_s[0] = 16'h0000;
        run_sweep(0, 1'b0, 1'b0);

        // Abort outside a sweep has no effect.
        abort_s[0] = 1'b1;
        tick();
        abort_s[0] = 1'b0;
        tick();
        check("abort_ignored_done", 32'({busy_s[0], done_s[0], pass_s[0]}), 32'b011);

        // Simultaneous start and abort in DONE: start wins.
        mask_s[0] = 16'($urandom);
        run_sweep(0, 1'b0, 1'b1);

        // Abort while vector 7 is settling.
        m = 16'($urandom);
        mask_s[0] = m;
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        repeat (36) tick();
        check("pre_abort", 32'({vec_s[0], busy_s[0]}), 32'({4'd7, 1'b1}));
        abort_s[0] = 1'b1;
        tick();
        abort_s[0] = 1'b0;
        check("abort_flags", 32'({busy_s[0], done_s[0], pass_s[0]}), 32'd0);
        check("abort_vec_hold", 32'(vec_s[0]), 32'd7);
        check("abort_cnt_hold", 32'(cnt_s[0]), 32'($countones(m & 16'h007f)));
        check("abort_ffv_hold", 32'(ffv_s[0]), 32'((m & 16'h007f) != 16'd0));
        check("abort_ffvec_hold", 32'(ffvec_s[0]), 32'(first_set(m & 16'h007f)));
        repeat (3) tick();
        check("abort_stays_idle", 32'({vec_s[0], busy_s[0], done_s[0]}), 32'({4'd7, 1'b0, 1'b0}));
        mask_s[0] = 16'($urandom);
        run_sweep(0, 1'b0, 1'b0);

        // Asynchronous reset mid-sweep at vector 9 with one mismatch recorded.
        mask_s[0] = 16'h0008;
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        repeat (46) tick();
        check("pre_rst", 32'({vec_s[0], cnt_s[0]}), 32'({4'd9, 5'd1}));
        #2 rst = 1'b1;
        #1;
        check_all_zero(0, "async_rst");
        #1 rst = 1'b0;
        tick();
        run_sweep(0, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            mask_s[0] = 16'($urandom) & 16'($urandom);
            run_sweep(0, 1'b0, 1'b0);
        end

        // Short settle with start held: no restart until DONE, then immediate restart.
        mask_s[1] = 16'($urandom);
        run_sweep(1, 1'b1, 1'b0);
        tick();
        check("held_start_restart", 32'({vec_s[1], busy_s[1], done_s[1], cnt_s[1], ffv_s[1]}),
              32'({4'd0, 1'b1, 1'b0, 5'd0, 1'b0}));
        start_s[1] = 1'b0;
        abort_s[1] = 1'b1;
        tick();
        abort_s[1] = 1'b0;
        check("dut1_abort", 32'({busy_s[1], done_s[1]}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
